// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one start/finish FP unit among N_REQ requesters
module fp_unit_arbiter #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_mul,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_s,
  output logic                   resp_err,
  output logic                   busy,
  output logic [WIDTH-1:0]       fp_a,
  output logic [WIDTH-1:0]       fp_b,
  output logic                   fp_mul,
  output logic                   fp_start,
  input  logic [WIDTH-1:0]       fp_s,
  input  logic                   fp_finish
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, id, gnt_id, idx;
  logic gnt_any, done, tmo;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic mul_q, err_q;
  logic [CW-1:0] cnt;
  always_comb begin
    gnt_id = '0;
    gnt_any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IW'((int'(ptr) + i) % N_REQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
    gnt = gnt_any ? (N_REQ'(1) << gnt_id) : '0;
  end
  // finish in the first WAIT cycle may be a stale level from the previous op
  assign done = (cnt != '0) && fp_finish;
  assign tmo  = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = gnt_any ? ISSUE : IDLE;
      ISSUE: state_n = WAIT;
      WAIT:  state_n = (done || tmo) ? RESP : WAIT;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      id <= '0;
      a_q <= '0;
      b_q <= '0;
      mul_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      if (state == IDLE && gnt_any) begin
        a_q <= req_a[gnt_id*WIDTH +: WIDTH];
        b_q <= req_b[gnt_id*WIDTH +: WIDTH];
        mul_q <= req_mul[gnt_id];
        id <= gnt_id;
        ptr <= (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + IW'(1);
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        if (done) begin
          res_q <= fp_s;
          err_q <= 1'b0;
        end else if (tmo) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end
  always_comb begin
    req_ready  = (state == IDLE) ? gnt : '0;
    busy       = state != IDLE;
    fp_start   = state == ISSUE;
    fp_a       = (state == ISSUE || state == WAIT) ? a_q : '0;
    fp_b       = (state == ISSUE || state == WAIT) ? b_q : '0;
    fp_mul     = (state == ISSUE || state == WAIT) ? mul_q : 1'b0;
    resp_valid = (state == RESP) ? (N_REQ'(1) << id) : '0;
    resp_s     = (state == RESP) ? res_q : '0;
    resp_err   = (state == RESP) ? err_q : 1'b0;
  end
endmodule
